// File: rtl/iltype_instr_gen.sv
// iltype_instr_gen: seeded constrained-random RV32I I-type instruction source.
// Emits SEED-driven LFSR-decoded ALU-immediate instructions, then flushes the
// consumer pipeline with NOPs and raises done.
// Optional feature macro: ILTYPE_GEN_LOAD_EN. When it is defined, LB/LBU loads
// are mixed into the stream. When it is undefined, only ALU I-type words are
// issued.
module iltype_instr_gen #(
  parameter logic [31:0] SEED       = 32'h0000_0262,
  parameter int unsigned NUM_INSTR  = 64,
  parameter int unsigned DRAIN_NOPS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [15:0] issued_count,
  output logic        done
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  // An all-zero Galois LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0] NUM_CNT   = 16'(NUM_INSTR);
  localparam logic [15:0] LAST_IDX  = 16'(NUM_INSTR - 1);
  localparam logic [3:0]  DRAIN_END = 4'(DRAIN_NOPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state_q;
  logic [31:0] lfsr_q, lfsr_d, lfsr_step;
  logic [31:0] instr_q, word_d;
  logic [15:0] cnt_q;
  logic [3:0]  drain_q;
  logic        done_q, valid_q;
  logic [11:0] imm_d;
  logic        il_choice;
  logic        accept;

  assign accept       = valid_q && instr_ready;
  assign instr_valid  = valid_q;
  assign instr        = instr_q;
  assign issued_count = cnt_q;
  assign done         = done_q;

  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

  // LFSR advances only when a random instruction is consumed. NOP accepts
  // in IDLE, DRAIN and DONE leave it untouched, so a restart continues the
  // sequence where the previous run stopped.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == S_RUN && accept) lfsr_d = lfsr_step;
  end

  // Decode the word that will be presented next, taken from the LFSR value
  // that will hold after this edge.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    word_d = NOP;
    imm_d  = lfsr_d[31:20];
`ifdef ILTYPE_GEN_LOAD_EN
    il_choice = lfsr_d[0];
`else
    il_choice = 1'b1;
`endif
    if (il_choice) begin
      // Shift-immediate forms keep only the shamt bits and the arithmetic flag.
      if (lfsr_d[14:12] == 3'd1)      imm_d = imm_d & 12'h01F;
      else if (lfsr_d[14:12] == 3'd5) imm_d = imm_d & 12'h41F;
      word_d = {imm_d, lfsr_d[19:15], lfsr_d[14:12], lfsr_d[11:7], OP_IMM};
    end else begin
      word_d = {lfsr_d[31:20], lfsr_d[19:15], lfsr_d[6], 2'b00, lfsr_d[11:7], OP_LOAD};
    end
  end

  // Run-control FSM with registered outputs and synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every
    // register in this block samples the values from before the edge.
    if (!reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      cnt_q   <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b1;
      instr_q <= NOP;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
            instr_q <= word_d;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (cnt_q != NUM_CNT) cnt_q <= cnt_q + 16'd1;
            if (cnt_q == LAST_IDX) begin
              state_q <= S_DRAIN;
              instr_q <= NOP;
            end else begin
              instr_q <= word_d;
            end
          end
        end
        S_DRAIN: begin
          if (accept) begin
            drain_q <= drain_q + 4'd1;
            if (drain_q == DRAIN_END) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iltype_instr_gen.sv
// tb_iltype_instr_gen: randomized self-checking bench for iltype_instr_gen.
// Four instances with different SEED/NUM_INSTR/DRAIN_NOPS share clk, reset
// and start. Each instance is compared against an expected-word queue built
// from the instruction-encoding rules.
// Honours ILTYPE_GEN_LOAD_EN so it matches the RTL build.
module tb_iltype_instr_gen;

  localparam int ND = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef ILTYPE_GEN_LOAD_EN
  localparam bit          LOAD_EN = 1'b1;
  localparam logic [31:0] EXP_D2  = 32'h1230_4003;
`else
  localparam bit          LOAD_EN = 1'b0;
  localparam logic [31:0] EXP_D2  = 32'h1230_0013;
`endif

  function automatic logic [31:0] seed_of(input int d);
    case (d)
      0:       return 32'h0050_A0A1;
      1:       return 32'hFFF0_5001;
      2:       return 32'h1230_0040;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic int num_of(input int d);
    case (d)
      0: return 24;
      1: return 2;
      2: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int drain_of(input int d);
    case (d)
      0, 1: return 5;
      2: return 1;
      default: return 2;
    endcase
  endfunction

  logic        clk, reset, start;
  logic        rdy     [ND];
  logic        valid_w [ND];
  logic [31:0] instr_w [ND];
  logic [15:0] cnt_w   [ND];
  logic        done_w  [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    iltype_instr_gen #(
      .SEED(seed_of(g)), .NUM_INSTR(num_of(g)), .DRAIN_NOPS(drain_of(g))
    ) u_dut (
      .clk(clk), .reset(reset), .start(start), .instr_ready(rdy[g]),
      .instr_valid(valid_w[g]), .instr(instr_w[g]),
      .issued_count(cnt_w[g]), .done(done_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: the encoding rules applied to one LFSR value.
  function automatic logic [31:0] model_word(input logic [31:0] l);
    int unsigned imm = l[31:20];
    int unsigned rs1 = l[19:15];
    int unsigned f3  = l[14:12];
    int unsigned rd  = l[11:7];
    if (LOAD_EN && l[0] == 1'b0)
      return 32'((imm << 20) + (rs1 << 15) + ((l[6] ? 4 : 0) << 12) + (rd << 7) + 3);
    if (f3 == 1)      imm = imm % 32;
    else if (f3 == 5) imm = (imm % 32) + ((imm / 1024) % 2) * 1024;
    return 32'((imm << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13);
  endfunction

  function automatic logic [31:0] model_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  logic [31:0] lfsr_m    [ND];
  logic [31:0] exp_q     [ND][$];
  int          rand_left [ND];
  int          exp_cnt   [ND];

  // Expected stream of one run: NUM random words, then DRAIN NOPs.
  task automatic load_run(input int d);
    exp_q[d].delete();
    for (int i = 0; i < num_of(d); i++) begin
      exp_q[d].push_back(model_word(lfsr_m[d]));
      lfsr_m[d] = model_step(lfsr_m[d]);
    end
    for (int i = 0; i < drain_of(d); i++) exp_q[d].push_back(NOP);
    rand_left[d] = num_of(d);
    exp_cnt[d]   = 0;
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s_instr%0d", tag, d), instr_w[d], NOP);
      check($sformatf("%s_valid%0d", tag, d), 32'(valid_w[d]), 32'd1);
      check($sformatf("%s_cnt%0d", tag, d), 32'(cnt_w[d]), 32'd0);
      check($sformatf("%s_done%0d", tag, d), 32'(done_w[d]), 32'd0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    for (int d = 0; d < ND; d++) rdy[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Scoreboard loop: check every instance each cycle, then drive random
  // ready (instance 0 also gets a forced 4-cycle stall). Pop on accept.
  task automatic run_phase(input string tag, input int budget);
    int cyc = 0;
    bit busy = 1'b1;
    while (busy && cyc < budget) begin
      busy = 1'b0;
      for (int d = 0; d < ND; d++) begin
        check($sformatf("%s_valid%0d", tag, d), 32'(valid_w[d]), 32'd1);
        check($sformatf("%s_cnt%0d", tag, d), 32'(cnt_w[d]), 32'(exp_cnt[d]));
        if (exp_q[d].size() > 0) begin
          busy = 1'b1;
          check($sformatf("%s_instr%0d", tag, d), instr_w[d], exp_q[d][0]);
          check($sformatf("%s_done%0d", tag, d), 32'(done_w[d]), 32'd0);
        end else begin
          check($sformatf("%s_instr%0d", tag, d), instr_w[d], NOP);
          check($sformatf("%s_done%0d", tag, d), 32'(done_w[d]), 32'd1);
        end
      end
      for (int d = 0; d < ND; d++) begin
        if (d == 0 && cyc >= 5 && cyc < 9) rdy[d] = 1'b0;
        else if (d == 1)                   rdy[d] = 1'b1;
        else                               rdy[d] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      for (int d = 0; d < ND; d++) begin
        if (rdy[d] && exp_q[d].size() > 0) begin
          void'(exp_q[d].pop_front());
          if (rand_left[d] > 0) begin
            rand_left[d]--;
            exp_cnt[d]++;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (busy) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    for (int d = 0; d < ND; d++) rdy[d] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("idle_hold");

    // Run 1 from reset: the first word decodes SEED. For instance 3 this is 0 -> 1.
    for (int d = 0; d < ND; d++) begin
      lfsr_m[d] = (seed_of(d) == 32'd0) ? 32'd1 : seed_of(d);
      load_run(d);
    end
    pulse_start();
    check("first_slti", instr_w[0], 32'h0050_A093);
    check("first_srai_mask", instr_w[1], 32'h41F0_5013);
    check("first_load_sel", instr_w[2], EXP_D2);
    check("first_zero_seed", instr_w[3], model_word(32'd1));
    run_phase("run1", 300);

    // Run 2 from DONE: the LFSR continues and the count restarts at zero.
    for (int d = 0; d < ND; d++) load_run(d);
    pulse_start();
    run_phase("run2", 300);

    // Run 3 aborted by reset: all outputs return to reset values, with no drain.
    pulse_start();
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("abort");
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_idle("post_abort");
    end

    // Run 4: reset reloaded SEED.
    for (int d = 0; d < ND; d++) begin
      lfsr_m[d] = (seed_of(d) == 32'd0) ? 32'd1 : seed_of(d);
      load_run(d);
    end
    pulse_start();
    run_phase("run4", 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
